// File: rtl/bpu_pkg.sv
// Shared branch-prediction-unit types.
//   PHT_IDX_W   : width of a pattern-history-table index
//   pht_upd_t   : one queued PHT update {index, taken}
//   upd_state_e : update-controller occupancy state
package bpu_pkg;

  localparam int unsigned PHT_IDX_W = 8;

  typedef struct packed {
    logic [PHT_IDX_W-1:0] index;
    logic                 taken;
  } pht_upd_t;

  typedef enum logic {StIdle, StBusy} upd_state_e;

endpackage

// File: rtl/pht_upd_fifo.sv
// Two-write, one-read update FIFO.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wr_en_i[1:0]      : per-lane write enables; lane0 is written before lane1
//   wr_data_i[1:0]    : per-lane write data
//   pop_i             : remove the head entry (caller guarantees non-empty)
//   flush_i           : empty the FIFO on the next edge (wins over push/pop)
//   rd_data_o         : head entry
//   count_o           : current occupancy
module pht_upd_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 wr_en_i,
  input  pht_upd_t [1:0]             wr_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output pht_upd_t                   rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pht_upd_t          mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     waddr0, waddr1;

  always_comb begin
    waddr0 = wptr_q;
    // Lane1 lands right after lane0 only if lane0 is also written.
    waddr1 = wptr_q + AW'(wr_en_i[0]);
    wptr_d = wptr_q + AW'(wr_en_i[0]) + AW'(wr_en_i[1]);
    rptr_d = rptr_q + AW'(pop_i);
    cnt_d  = cnt_q + CW'(wr_en_i[0]) + CW'(wr_en_i[1]) - CW'(pop_i);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (wr_en_i[0]) mem_q[waddr0] <= wr_data_i[0];
      if (wr_en_i[1]) mem_q[waddr1] <= wr_data_i[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/pht_upd_ctrl.sv
// PHT update controller: queues up to two branch-resolve updates per cycle and
// issues them to the single-ported PHT one per cycle, in arrival order.
//   clk, rst          : clock, asynchronous active-high reset
//   upd_valid/index/taken : per-lane update requests (lane0 older)
//   upd_ready         : at least two FIFO entries free
//   hold              : PHT port busy, do not issue
//   flush             : drop all queued and same-cycle updates
//   update_en, index_up, taken_actual : registered PHT update strobe/payload
//   overflow          : sticky, a valid lane arrived while upd_ready was low
// Optional macro PHT_UPD_BYPASS_EN: when defined, an update arriving into an
// empty FIFO with hold=0 skips the queue and issues on the push edge.
module pht_upd_ctrl
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    upd_valid,
  input  logic [1:0][PHT_IDX_W-1:0]     upd_index,
  input  logic [1:0]                    upd_taken,
  output logic                          upd_ready,
  input  logic                          hold,
  input  logic                          flush,
  output logic                          update_en,
  output logic [PHT_IDX_W-1:0]          index_up,
  output logic                          taken_actual,
  output logic                          overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  upd_state_e      state_q, state_d;
  logic            update_en_q, overflow_q;
  pht_upd_t        out_q;

  pht_upd_t [1:0]  lane;
  pht_upd_t        head, byp_data;
  logic [1:0]      acc, wr_en;
  logic            pop, byp;
  logic [CW-1:0]   fifo_cnt, cnt_next;

  always_comb begin
    lane[0]   = '{index: upd_index[0], taken: upd_taken[0]};
    lane[1]   = '{index: upd_index[1], taken: upd_taken[1]};
    upd_ready = (fifo_cnt <= CW'(DEPTH - 2));
    acc       = upd_valid & {2{upd_ready & ~flush}};
    pop       = !hold && !flush && (state_q == StBusy);
`ifdef PHT_UPD_BYPASS_EN
    // Bypass only when nothing is queued, so ordering is preserved.
    byp      = (state_q == StIdle) && !hold && !flush && (|acc);
    wr_en    = byp ? ((acc == 2'b11) ? 2'b10 : 2'b00) : acc;
    byp_data = acc[0] ? lane[0] : lane[1];
`else
    byp      = 1'b0;
    wr_en    = acc;
    byp_data = lane[0];
`endif
    cnt_next = flush ? '0
                     : fifo_cnt + CW'(wr_en[0]) + CW'(wr_en[1]) - CW'(pop);
    state_d  = (cnt_next != '0) ? StBusy : StIdle;
  end

  pht_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (lane),
    .pop_i     (pop),
    .flush_i   (flush),
    .rd_data_o (head),
    .count_o   (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      update_en_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Lanes discarded by flush do not count as overflow.
      if ((|upd_valid) && !upd_ready && !flush) overflow_q <= 1'b1;
      if (pop) begin
        update_en_q <= 1'b1;
        out_q       <= head;
      end else if (byp) begin
        update_en_q <= 1'b1;
        out_q       <= byp_data;
      end else begin
        update_en_q <= 1'b0;
      end
    end
  end

  assign update_en    = update_en_q;
  assign index_up     = out_q.index;
  assign taken_actual = out_q.taken;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pht_upd_ctrl.sv
module tb_pht_upd_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      upd_valid;
  logic [1:0][7:0] upd_index;
  logic [1:0]      upd_taken;
  logic            upd_ready;
  logic            hold;
  logic            flush;
  logic            update_en;
  logic [7:0]      index_up;
  logic            taken_actual;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  pht_upd_ctrl #(
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .hold         (hold),
    .flush        (flush),
    .update_en    (update_en),
    .index_up     (index_up),
    .taken_actual (taken_actual),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    upd_valid = 2'b00;
    upd_index = '0;
    upd_taken = 2'b00;
  endtask

  task automatic lanes(input logic [1:0] v, input logic [7:0] i0, input logic t0,
                       input logic [7:0] i1, input logic t1);
    upd_valid    = v;
    upd_index[0] = i0;
    upd_taken[0] = t0;
    upd_index[1] = i1;
    upd_taken[1] = t1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    hold  = 1'b0;
    flush = 1'b0;
    do_reset();

    // Reset state
    chk("rst_en", update_en, 0);
    chk("rst_idx", index_up, 0);
    chk("rst_tk", taken_actual, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdy", upd_ready, 1);

    // Single lane0 into idle: update two edges later, for one cycle
    lanes(2'b01, 8'h12, 1'b1, 8'h00, 1'b0);
    step();
    idle_in();
    chk("s1_en_e1", update_en, 0);
    step();
    chk("s1_en_e2", update_en, 1);
    chk("s1_idx", index_up, 8'h12);
    chk("s1_tk", taken_actual, 1);
    step();
    chk("s1_en_e3", update_en, 0);
    chk("s1_idx_keep", index_up, 8'h12);

    // Both lanes in one cycle: two consecutive updates, lane0 first
    lanes(2'b11, 8'h05, 1'b1, 8'h06, 1'b0);
    step();
    idle_in();
    chk("s2_en_e1", update_en, 0);
    step();
    chk("s2_en_a", update_en, 1);
    chk("s2_idx_a", index_up, 8'h05);
    chk("s2_tk_a", taken_actual, 1);
    step();
    chk("s2_en_b", update_en, 1);
    chk("s2_idx_b", index_up, 8'h06);
    chk("s2_tk_b", taken_actual, 0);
    step();
    chk("s2_en_end", update_en, 0);

    // Fill under hold, overflow on a dropped lane, then drain in order
    hold = 1'b1;
    lanes(2'b11, 8'h10, 1'b1, 8'h11, 1'b0);
    step();
    chk("s3_rdy_half", upd_ready, 1);
    lanes(2'b11, 8'h12, 1'b1, 8'h13, 1'b0);
    step();
    idle_in();
    chk("s3_rdy_full", upd_ready, 0);
    chk("s3_en_hold", update_en, 0);
    chk("s3_ovf_pre", overflow, 0);
    lanes(2'b01, 8'h14, 1'b1, 8'h00, 1'b0);
    step();
    idle_in();
    chk("s3_ovf", overflow, 1);
    chk("s3_rdy_still", upd_ready, 0);
    step();
    step();
    chk("s3_en_hold2", update_en, 0);
    hold = 1'b0;
    step();
    chk("s3_en0", update_en, 1);
    chk("s3_idx0", index_up, 8'h10);
    chk("s3_tk0", taken_actual, 1);
    step();
    chk("s3_en1", update_en, 1);
    chk("s3_idx1", index_up, 8'h11);
    chk("s3_tk1", taken_actual, 0);
    step();
    chk("s3_en2", update_en, 1);
    chk("s3_idx2", index_up, 8'h12);
    step();
    chk("s3_en3", update_en, 1);
    chk("s3_idx3", index_up, 8'h13);
    step();
    chk("s3_en_end", update_en, 0);
    chk("s3_idx_keep", index_up, 8'h13);
    chk("s3_rdy_end", upd_ready, 1);

    // Flush with three queued entries and a same-cycle lane
    do_reset();
    hold = 1'b1;
    lanes(2'b11, 8'h20, 1'b1, 8'h21, 1'b1);
    step();
    lanes(2'b01, 8'h22, 1'b0, 8'h00, 1'b0);
    step();
    chk("s4_rdy_3q", upd_ready, 0);
    hold  = 1'b0;
    flush = 1'b1;
    lanes(2'b01, 8'h23, 1'b1, 8'h00, 1'b0);
    step();
    flush = 1'b0;
    idle_in();
    chk("s4_en_flush", update_en, 0);
    chk("s4_ovf_keep", overflow, 0);
    chk("s4_rdy", upd_ready, 1);
    chk("s4_cnt", 32'(dut.fifo_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s4_no_upd", update_en, 0);
    end

    // Reset asserted mid-cycle with entries queued and an update in flight
    hold = 1'b1;
    lanes(2'b11, 8'h30, 1'b1, 8'h31, 1'b1);
    step();
    idle_in();
    hold = 1'b0;
    step();
    chk("s5_en_pre", update_en, 1);
    chk("s5_idx_pre", index_up, 8'h30);
    #3;
    rst = 1'b1;
    #1;
    chk("s5_en_async", update_en, 0);
    chk("s5_idx_async", index_up, 0);
    chk("s5_tk_async", taken_actual, 0);
    step();
    chk("s5_en_in_rst", update_en, 0);
    rst = 1'b0;
    #1;
    chk("s5_rdy", upd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_no_upd", update_en, 0);
    end

    // Sustained one push per cycle
    for (int i = 0; i < 10; i++) begin
      lanes(2'b01, 8'(8'h40 + i), 1'(i % 2), 8'h00, 1'b0);
      step();
      if (i == 0) begin
        chk("s6_en_first", update_en, 0);
      end else begin
        chk("s6_en", update_en, 1);
        chk("s6_idx", index_up, 32'(8'h40 + i - 1));
        chk("s6_tk", taken_actual, 32'((i - 1) % 2));
      end
      chk("s6_occ", 32'(dut.fifo_cnt), 1);
      chk("s6_ovf", overflow, 0);
    end
    idle_in();
    step();
    chk("s6_en_last", update_en, 1);
    chk("s6_idx_last", index_up, 8'h49);
    step();
    chk("s6_en_end", update_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_upd_ctrl.md
PHT_UPD_CTRL -- requirements
Module: pht_upd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the update FIFO depth in entries (power of two, at least 2).
REQ-002 SHALL have ports: clk, input, 1, the single clock.
REQ-003 SHALL have ports: rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: upd_valid, input, [1:0], per-lane branch-resolve update request (lane0 older).
REQ-005 SHALL have ports: upd_index, input, [1:0][7:0], per-lane PHT index.
REQ-006 SHALL have ports: upd_taken, input, [1:0], per-lane actual direction.
REQ-007 SHALL have ports: upd_ready, output, 1, high when at least 2 FIFO entries are free.
REQ-008 SHALL have ports: hold, input, 1, the PHT port is busy; no issue this cycle.
REQ-009 SHALL have ports: flush, input, 1, discard all queued and pending updates.
REQ-010 SHALL have ports: update_en, output, 1, PHT single update strobe.
REQ-011 SHALL have ports: index_up, output, [7:0], PHT update index.
REQ-012 SHALL have ports: taken_actual, output, 1, PHT update direction.
REQ-013 SHALL have ports: overflow, output, 1, sticky flag set when a valid lane arrives while upd_ready=0.

Function
REQ-014 SHALL accept a lane only when upd_valid[i]=1 and upd_ready=1, pushing lane0 before lane1 in the same cycle (0, 1 or 2 pushes per cycle).
REQ-015 SHALL drop a lane arriving while upd_ready=0, leave the FIFO unchanged, and set overflow.
REQ-016 SHALL register update_en, index_up and taken_actual; each cycle with hold=0 and the FIFO non-empty, they load the FIFO head and pop it.
REQ-017 SHALL otherwise load update_en=0 and retain index_up and taken_actual.
REQ-018 SHALL issue at most one update per cycle, in strict arrival order.
REQ-019 SHALL have a latency, with the bypass disabled, of 2 edges: the push edge, then the edge asserting update_en.
REQ-020 SHALL allow a push and a pop in the same cycle; occupancy changes by pushes minus pops, and pointers wrap modulo DEPTH.
REQ-021 SHALL maintain a 2-state FSM, IDLE (occupancy 0) and BUSY (occupancy >0).
REQ-022 SHALL transition IDLE->BUSY on any accepted push not bypassed.
REQ-023 SHALL transition BUSY->IDLE when the last entry pops with no push.
REQ-024 SHALL, on flush=1, empty the FIFO next edge, force update_en=0 next edge, and enter IDLE.
REQ-025 SHALL let flush win over simultaneous pushes and pops: same-cycle lanes are discarded and overflow is not set by them.
REQ-026 SHALL hold the FIFO and output with update_en=0 while hold=1 for any number of cycles, with no loss.
REQ-027 SHALL clear overflow only by reset.

Reset
REQ-028 SHALL, on rst assertion and asynchronously, force update_en=0, index_up=0, taken_actual=0, overflow=0, empty FIFO pointers and occupancy, and state IDLE.
REQ-029 SHALL drive upd_ready=1 out of reset.
REQ-030 SHALL discard any in-progress updates on reset mid-operation, and SHALL NOT emit any update_en during reset.

Configuration
REQ-031 SHALL provide macro PHT_UPD_BYPASS_EN.
REQ-032 SHALL, when PHT_UPD_BYPASS_EN is defined, load the oldest accepted lane directly into the output registers (latency 1 edge) when the FIFO is empty, hold=0 and flush=0, queueing only a second lane.
REQ-033 SHALL, when PHT_UPD_BYPASS_EN is undefined, route every update through the FIFO (latency 2 edges).

Structure
REQ-034 SHALL place typedef pht_upd_t {index[7:0], taken} and localparam PHT_IDX_W=8 in shared package bpu_pkg.
REQ-035 SHALL implement the FIFO as sub-module pht_upd_fifo (2-write, 1-read, DEPTH entries, occupancy output); the FSM, bypass and output registers SHALL stay in pht_upd_ctrl.

Verification
REQ-036 SHALL verify: single lane0 {idx=0x12, taken=1} into idle, hold=0 -> update_en=1, index_up=0x12, taken_actual=1 exactly 2 edges later (1 with bypass), for one cycle.
REQ-037 SHALL verify: both lanes {0x05,1},{0x06,0} in one cycle -> two consecutive update_en cycles, 0x05 then 0x06.
REQ-038 SHALL verify: DEPTH=4, hold=1, push 2+2 -> upd_ready=0; a further lane0 is dropped and overflow=1; release hold -> exactly 4 updates in order.
REQ-039 SHALL verify: 3 entries queued, flush=1 with lane0 valid the same cycle -> update_en=0 from the next edge, FIFO empty, no later update, overflow unchanged.
REQ-040 SHALL verify: 2 entries queued, assert rst mid-cycle -> outputs 0 immediately; after release, upd_ready=1 and no update_en.
REQ-041 SHALL verify: sustained 1 push/cycle for 10 cycles with hold=0 -> 10 in-order updates, occupancy never exceeds 1, no overflow.
